sram_responder: RTL and testbench

Synthesizable responder for the board's external 16-bit asynchronous-style SRAM bus: it answers the address/data/strobe traffic that the memory controller initiates, backed by an internal word array. It lets the CPU/memory-controller path run in simulation or on an FPGA without the physical SRAM, and exposes a preload port so boot images can be written before the CPU is released.

---
 rtl/sram_responder.sv | 169 ++++++++++++++++
 tb/tb_sram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Behavioural stand-in for the external 16-bit asynchronous SRAM: answers controller
// read/write strobes from an internal word array and accepts boot-image preload while idle.
module sram_responder #(
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned DEPTH_WIDTH  = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [15:0]            memDataBus,
    input  logic [ADDR_WIDTH-1:0]  memAddrBus,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic                   memEnable,
    input  logic                   loadValid,
    input  logic [DEPTH_WIDTH-1:0] loadAddr,
    input  logic [15:0]            loadData,
    output logic                   loadReady,
    output logic                   busy,
    output logic                   outOfRange,
    output logic                   errConflict
);

    localparam int unsigned Depth   = 1 << DEPTH_WIDTH;
    localparam logic [2:0]  LatLoad = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StDrive,
        StWrite
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   drive_q, drive_d;
    logic [DEPTH_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [15:0]            hold_data_q, hold_data_d;
    logic                   oor_q, oor_d;
    logic                   conflict_q, conflict_d;

    logic [15:0] mem_q [Depth];

    logic active, rd_req, wr_req, addr_oor;
    logic capture, latch, commit, load_fire;

    assign active   = ~memEnable;
    assign rd_req   = active & ~memRead;
    // Write wins over read, so a conflicting cycle is handled as a write.
    assign wr_req   = active & ~memWrite;
    assign addr_oor = |memAddrBus[ADDR_WIDTH-1:DEPTH_WIDTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        raddr_d     = raddr_q;
        rdata_d     = rdata_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        oor_d       = oor_q;
        capture     = 1'b0;
        latch       = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_req) begin
                    state_d = StWrite;
                    capture = 1'b1;
                end else if (rd_req) begin
                    state_d = StReadWait;
                    latch   = 1'b1;
                end
            end
            StReadWait: begin
                if (!rd_req) begin
                    state_d = StIdle;
                end else if (wr_req) begin
                    state_d = StWrite;
                    capture = 1'b1;
                end else if (cnt_q == 3'd0) begin
                    state_d = StDrive;
                    rdata_d = mem_q[raddr_q[DEPTH_WIDTH-1:0]];
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDrive: begin
                if (!rd_req) begin
                    state_d = StIdle;
                end else if (wr_req) begin
                    state_d = StWrite;
                    capture = 1'b1;
                end else if (memAddrBus != raddr_q) begin
                    state_d = StReadWait;
                    latch   = 1'b1;
                end
            end
            StWrite: begin
                if (wr_req) begin
                    capture = 1'b1;
                end else begin
                    // Commit what was last captured, not what is on the bus now.
                    commit  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            hold_addr_d = memAddrBus[DEPTH_WIDTH-1:0];
            hold_data_d = memDataBus;
            oor_d       = addr_oor;
        end
        if (latch) begin
            raddr_d = memAddrBus;
            cnt_d   = LatLoad;
            oor_d   = addr_oor;
        end
    end

    assign drive_d    = (state_d == StDrive);
    assign conflict_d = active & ~memRead & ~memWrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            raddr_q     <= '0;
            rdata_q     <= 16'h0000;
            drive_q     <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= 16'h0000;
            oor_q       <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            raddr_q     <= raddr_d;
            rdata_q     <= rdata_d;
            drive_q     <= drive_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            oor_q       <= oor_d;
            conflict_q  <= conflict_d;
        end
    end

    assign loadReady = (state_q == StIdle) & memEnable;
    assign load_fire = loadValid & loadReady;

    // Storage survives reset; a write interrupted by reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            mem_q[hold_addr_q] <= hold_data_q;
        end else if (load_fire) begin
            mem_q[loadAddr] <= loadData;
        end
    end

    assign memDataBus  = drive_q ? rdata_q : 16'hzzzz;
    assign busy        = (state_q != StIdle);
    assign outOfRange  = oor_q;
    assign errConflict = conflict_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: one instance at read latency 1, one at latency 3.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b1;
    logic        memWrite = 1'b1;
    logic        memEnable = 1'b1;
    logic [17:0] memAddrBus = 18'h0;
    logic        loadValid = 1'b0;
    logic [9:0]  loadAddr = 10'h0;
    logic [15:0] loadData = 16'h0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_data = 16'h0;
    logic        pr1 = 1'b0;
    logic        pr3 = 1'b0;

    wire [15:0] bus1;
    wire [15:0] bus3;
    logic loadReady1, busy1, oor1, conf1;
    logic loadReady3, busy3, oor3, conf3;

    int checks = 0;
    int errors = 0;

    // Probe drives 0 onto a bus; it reads back 0 only if the DUT has released it.
    assign bus1 = tb_oe ? tb_data : (pr1 ? 16'h0000 : 16'hzzzz);
    assign bus3 = tb_oe ? tb_data : (pr3 ? 16'h0000 : 16'hzzzz);

    always #5 clk = ~clk;

    sram_responder #(.ADDR_WIDTH(18), .DEPTH_WIDTH(10), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .memDataBus(bus1), .memAddrBus(memAddrBus),
        .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable),
        .loadValid(loadValid), .loadAddr(loadAddr), .loadData(loadData),
        .loadReady(loadReady1), .busy(busy1), .outOfRange(oor1), .errConflict(conf1)
    );

    sram_responder #(.ADDR_WIDTH(18), .DEPTH_WIDTH(10), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .memDataBus(bus3), .memAddrBus(memAddrBus),
        .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable),
        .loadValid(loadValid), .loadAddr(loadAddr), .loadData(loadData),
        .loadReady(loadReady3), .busy(busy3), .outOfRange(oor3), .errConflict(conf3)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic probe1(input string tag);
        pr1 = 1'b1;
        #1;
        chk(tag, bus1, 16'h0000);
        pr1 = 1'b0;
    endtask

    task automatic probe3(input string tag);
        pr3 = 1'b1;
        #1;
        chk(tag, bus3, 16'h0000);
        pr3 = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        loadAddr  = a;
        loadData  = d;
        loadValid = 1'b1;
        chk1("load_ready", loadReady1, 1'b1);
        chk1("load_ready3", loadReady3, 1'b1);
        step();
        loadValid = 1'b0;
    endtask

    task automatic release_bus();
        memRead   = 1'b1;
        memWrite  = 1'b1;
        memEnable = 1'b1;
        tb_oe     = 1'b0;
        step();
    endtask

    initial begin
        // Reset with bus inactive
        step();
        step();
        probe1("rst_bus_z");
        chk1("rst_busy", busy1, 1'b0);
        chk1("rst_load_ready", loadReady1, 1'b1);
        chk1("rst_conflict", conf1, 1'b0);
        chk1("rst_oor", oor1, 1'b0);
        rst = 1'b0;

        preload(10'h005, 16'hBEEF);
        preload(10'h000, 16'h1111);
        preload(10'h001, 16'h2222);
        preload(10'h020, 16'hAAAA);

        // Read 0x005, latency 1
        memEnable  = 1'b0;
        memRead    = 1'b0;
        memAddrBus = 18'h00005;
        step();
        chk1("rd_busy", busy1, 1'b1);
        chk1("rd_load_ready_low", loadReady1, 1'b0);
        probe1("rd_wait_z");
        step();
        chk("rd_data", bus1, 16'hBEEF);
        release_bus();
        probe1("rd_release_z");
        chk1("rd_idle", busy1, 1'b0);

        // Write 0x1234 to 0x010; data changes on second cycle, address moves on commit
        memEnable  = 1'b0;
        memWrite   = 1'b0;
        memAddrBus = 18'h00010;
        tb_oe      = 1'b1;
        tb_data    = 16'h5555;
        step();
        chk1("wr_busy", busy1, 1'b1);
        tb_data = 16'h1234;
        step();
        memWrite   = 1'b1;
        memEnable  = 1'b1;
        tb_oe      = 1'b0;
        memAddrBus = 18'h00099;
        step();
        chk1("wr_commit_idle", busy1, 1'b0);
        memEnable  = 1'b0;
        memRead    = 1'b0;
        memAddrBus = 18'h00010;
        step();
        step();
        chk("raw_data", bus1, 16'h1234);
        release_bus();

        // Out-of-range alias, then address change while driving
        memEnable  = 1'b0;
        memRead    = 1'b0;
        memAddrBus = 18'h00400;
        step();
        chk1("oor_set", oor1, 1'b1);
        chk1("oor_set3", oor3, 1'b1);
        step();
        chk("oor_alias_data", bus1, 16'h1111);
        memAddrBus = 18'h00001;
        step();
        chk1("oor_clear", oor1, 1'b0);
        probe1("addr_change_z");
        step();
        chk("addr_change_data", bus1, 16'h2222);
        release_bus();

        // Conflict: read and write low together for three cycles
        memEnable  = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memAddrBus = 18'h00030;
        tb_oe      = 1'b1;
        tb_data    = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("conflict_pulse", conf1, 1'b1);
            chk1("conflict_pulse3", conf3, 1'b1);
            chk("conflict_bus", bus1, 16'h7777);
        end
        release_bus();
        chk1("conflict_end", conf1, 1'b0);
        chk1("conflict_idle", busy1, 1'b0);
        memEnable = 1'b0;
        memRead   = 1'b0;
        step();
        step();
        chk("conflict_committed", bus1, 16'h7777);
        release_bus();

        // Reset during a write to 0x020 discards it
        memEnable  = 1'b0;
        memWrite   = 1'b0;
        memAddrBus = 18'h00020;
        tb_oe      = 1'b1;
        tb_data    = 16'h5A5A;
        step();
        step();
        chk1("wr2_busy", busy1, 1'b1);
        rst       = 1'b1;
        memWrite  = 1'b1;
        memEnable = 1'b1;
        tb_oe     = 1'b0;
        step();
        chk1("rst_wr_idle", busy1, 1'b0);
        chk1("rst_wr_idle3", busy3, 1'b0);
        rst = 1'b0;

        // Latency-3 read of 0x020 next to the latency-1 instance
        memEnable = 1'b0;
        memRead   = 1'b0;
        step();
        probe3("lat3_n0_z");
        step();
        chk("lat1_kept", bus1, 16'hAAAA);
        probe3("lat3_n1_z");
        step();
        probe3("lat3_n2_z");
        step();
        chk("lat3_data", bus3, 16'hAAAA);
        chk1("lat3_busy", busy3, 1'b1);
        release_bus();
        probe3("lat3_release_z");
        probe1("lat1_release_z");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
